// File: rtl/key_event_if.sv
// -----------------------------------------------------------------------------
// key_event_if
// Event channel between key_event_debouncer (master) and the control logic
// (slave).
//
// Handshake: evt_valid/evt_ready follow strict valid/ready rules. A transfer
// happens on the rising clk edge where evt_valid & evt_ready are both 1. While
// evt_valid is 1, evt_code stays stable until that transfer. evt_valid never
// depends on evt_ready. The consumer may raise or lower evt_ready at any time.
//
// Signals:
//   evt_valid    master->slave  FIFO head holds an event
//   evt_ready    slave->master  consumer accepts the head
//   evt_code     master->slave  [5]=1 press / 0 release, [4:0] source index
//   evt_overflow master->slave  sticky flag: an event was lost
// -----------------------------------------------------------------------------
interface key_event_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [5:0] evt_code;
  logic       evt_overflow;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_overflow,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_overflow,
    output evt_ready
  );
endinterface

// File: rtl/key_event_debouncer.sv
// -----------------------------------------------------------------------------
// key_event_debouncer
// Debounces the parallel key-driver frame (16 DIP bits and 5 push buttons)
// across consecutive latched frames. It presents the stable levels and queues
// press/release events in a small first-word-fall-through FIFO.
//
// Source index map: push[i] -> i (0..4), dip[j] -> 5+j (5..20).
//
// Build option: define KEY_EVT_DIP_EN to make DIP bits generate events like
// the push buttons. When it is undefined, DIP bits are only debounced onto
// dip_stable and the event scanner covers indices 0..4.
//
// Parameters:
//   DEBOUNCE_FRAMES  consecutive differing frames needed to flip a bit (2..15)
//   FIFO_DEPTH       event FIFO entries (power of 2, 2..32)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   dip          raw DIP frame
//   push         raw push frame (1 = pressed)
//   latch        1-cycle strobe: dip/push hold a new frame this cycle
//   dip_stable   debounced DIP levels
//   push_stable  debounced push levels
//   evt          event channel (key_event_if.master)
// -----------------------------------------------------------------------------
module key_event_debouncer #(
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] dip,
  input  logic [4:0]  push,
  input  logic        latch,
  output logic [15:0] dip_stable,
  output logic [4:0]  push_stable,
  key_event_if.master evt
);

  localparam int NSRC = 21;
`ifdef KEY_EVT_DIP_EN
  localparam int NEVT = 21;
`else
  localparam int NEVT = 5;
`endif
  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_FRAMES - 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  // ---------------------------------------------------------------------------
  // Per-bit debounce
  // ---------------------------------------------------------------------------
  logic [NSRC-1:0] raw;
  logic [NSRC-1:0] stable_q;
  logic [NSRC-1:0] flip;
  logic [3:0]      cnt_q [NSRC];

  assign raw = {dip, push};

  // A bit flips on the latched frame that completes the run of differing frames.
  always_comb begin
    flip = '0;
    for (int i = 0; i < NSRC; i++) begin
      flip[i] = latch && (raw[i] != stable_q[i]) && (cnt_q[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      for (int i = 0; i < NSRC; i++) cnt_q[i] <= '0;
    end else if (latch) begin
      stable_q <= stable_q ^ flip;
      for (int i = 0; i < NSRC; i++) begin
        if (raw[i] == stable_q[i] || flip[i]) cnt_q[i] <= '0;
        else                                  cnt_q[i] <= cnt_q[i] + 4'd1;
      end
    end
  end

  assign push_stable = stable_q[4:0];
  assign dip_stable  = stable_q[20:5];

  // ---------------------------------------------------------------------------
  // FIFO pointers and status
  // ---------------------------------------------------------------------------
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, count;
  logic [5:0]    mem [FIFO_DEPTH];
  logic [5:0]    head_q;
  logic          full, empty, pop;

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (count == PW'(FIFO_DEPTH));
  assign pop   = !empty && evt.evt_ready;

  // ---------------------------------------------------------------------------
  // Pending-mask scanner: the lowest pending index goes into the FIFO, one per cycle
  // ---------------------------------------------------------------------------
  logic [NEVT-1:0] pending_q, pending_d, enq_mask, flip_evt;
  logic [4:0]      enq_idx;
  logic [5:0]      enq_code;
  logic            do_enq, ovf_set, overflow_q;

  assign flip_evt = flip[NEVT-1:0];

  always_comb begin
    enq_idx = '0;
    for (int i = NEVT - 1; i >= 0; i--) begin
      if (pending_q[i]) enq_idx = 5'(i);
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign do_enq   = (|pending_q) && (!full || pop);
  assign enq_mask = do_enq ? (NEVT'(1) << enq_idx) : '0;
  // The code carries the stable value before any toggle in this cycle.
  assign enq_code = {stable_q[enq_idx], enq_idx};

  // A toggle on a bit still pending means it flipped back before draining.
  // Both edges are dropped and the loss is flagged. A bit enqueued in this
  // cycle has already left the mask, so its toggle starts a new event.
  assign pending_d = (pending_q & ~enq_mask) ^ flip_evt;
  assign ovf_set   = |(flip_evt & pending_q & ~enq_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (ovf_set) overflow_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage with a registered head (first-word-fall-through)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr_q[AW-1:0]] <= enq_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      if (do_enq) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
      // The head reloads only when the visible entry changes. When the FIFO
      // is empty, the head holds the last code.
      if (do_enq && (empty || (pop && count == PW'(1))))
        head_q <= enq_code;
      else if (pop && count > PW'(1))
        head_q <= mem[AW'(rd_ptr_q[AW-1:0] + AW'(1))];
    end
  end

  assign evt.evt_valid    = !empty;
  assign evt.evt_code     = head_q;
  assign evt.evt_overflow = overflow_q;

endmodule
